// File: rtl/param_barrel_shifter_pipe.sv
// Pipelined WIDTH-bit shifter/rotator (LSL/LSR/ASR/ROL) with one registered log2 stage per shift-amount bit.
// Define BARREL_CARRY_OUT_EN to add out_carry and its carry pipeline; by default both are absent.
module param_barrel_shifter_pipe #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
`ifdef BARREL_CARRY_OUT_EN
  ,
  output logic             out_carry
`endif
);

  typedef enum logic [1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROL = 2'b11
  } mode_e;

  logic advance;

  // The whole pipe moves in lockstep; a stalled output freezes every stage.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar i = 0; i < SHW; i++) begin : g_stage
    localparam int S  = 1 << i;
    localparam int BW = SHW - i;

    logic             v_in;
    logic [WIDTH-1:0] d_in;
    logic [1:0]       m_in;
    logic             s_in;
    logic [BW-1:0]    b_in;
    logic [WIDTH-1:0] d_nxt;
    logic             v_q;
    logic [WIDTH-1:0] d_q;

    if (i == 0) begin : g_src
      assign v_in = in_valid;
      assign d_in = a;
      assign m_in = mode;
      assign s_in = a[WIDTH-1];
      assign b_in = b;
    end else begin : g_src
      assign v_in = g_stage[i-1].v_q;
      assign d_in = g_stage[i-1].d_q;
      assign m_in = g_stage[i-1].g_ctl.m_q;
      assign s_in = g_stage[i-1].g_ctl.s_q;
      assign b_in = g_stage[i-1].g_ctl.b_q;
    end

    // b_in[0] is this stage's shift bit; the original sign travels with the item for ASR fill.
    always_comb begin
      d_nxt = d_in;
      if (b_in[0]) begin
        case (m_in)
          MODE_LSL: d_nxt = d_in << S;
          MODE_LSR: d_nxt = d_in >> S;
          MODE_ASR: d_nxt = (d_in >> S) | ({WIDTH{s_in}} << (WIDTH - S));
          default:  d_nxt = (d_in << S) | (d_in >> (WIDTH - S));
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (advance) begin
        v_q <= v_in;
        d_q <= d_nxt;
      end
    end

    if (i < SHW - 1) begin : g_ctl
      logic [1:0]    m_q;
      logic          s_q;
      logic [BW-2:0] b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          m_q <= '0;
          s_q <= 1'b0;
          b_q <= '0;
        end else if (advance) begin
          m_q <= m_in;
          s_q <= s_in;
          b_q <= b_in[BW-1:1];
        end
      end
    end

`ifdef BARREL_CARRY_OUT_EN
    logic c_in;
    logic c_nxt;
    logic c_q;

    if (i == 0) begin : g_csrc
      assign c_in = 1'b0;
    end else begin : g_csrc
      assign c_in = g_stage[i-1].c_q;
    end

    // The last stage that actually shifts decides the carry; later idle stages pass it on.
    always_comb begin
      c_nxt = c_in;
      if (b_in[0]) begin
        if (m_in == MODE_LSL || m_in == MODE_ROL) c_nxt = d_in[WIDTH-S];
        else                                       c_nxt = d_in[S-1];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)          c_q <= 1'b0;
      else if (advance) c_q <= c_nxt;
    end
`endif
  end

  assign out_valid = g_stage[SHW-1].v_q;
  assign out       = g_stage[SHW-1].d_q;
`ifdef BARREL_CARRY_OUT_EN
  assign out_carry = g_stage[SHW-1].c_q;
`endif

endmodule

// File: tb/tb_param_barrel_shifter_pipe.sv
// Bench for param_barrel_shifter_pipe: WIDTH=8 instance driven through a scoreboard, plus a WIDTH=32 instance.
// Carry checks are active when BARREL_CARRY_OUT_EN is defined.
module tb_param_barrel_shifter_pipe;
  localparam int SW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, out;
  logic [2:0] b;
  logic [1:0] mode;

  logic        in_valid32, in_ready32, out_valid32, out_ready32;
  logic [31:0] a32, out32;
  logic [4:0]  b32;
  logic [1:0]  mode32;
`ifdef BARREL_CARRY_OUT_EN
  logic out_carry, out_carry32;
`endif

  param_barrel_shifter_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .out(out)
`ifdef BARREL_CARRY_OUT_EN
    , .out_carry(out_carry)
`endif
  );

  param_barrel_shifter_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .mode(mode32), .out_valid(out_valid32), .out_ready(out_ready32), .out(out32)
`ifdef BARREL_CARRY_OUT_EN
    , .out_carry(out_carry32)
`endif
  );

  typedef struct {
    logic [7:0] data;
    logic       carry;
    int         cyc;
    bit         chk_lat;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: shift a doubled word and pick the window, independent of the staged structure.
  function automatic logic [8:0] model8(input logic [7:0] x, input logic [2:0] k, input logic [1:0] m);
    logic [15:0] t;
    logic [7:0]  r;
    logic        c;
    case (m)
      2'b00: begin t = {8'h00, x} << k; r = t[7:0];  c = t[8]; end
      2'b01: begin t = {x, 8'h00} >> k; r = t[15:8]; c = t[7]; end
      2'b10: begin t = 16'($signed({x, 8'h00}) >>> k); r = t[15:8]; c = t[7]; end
      default: begin t = {x, x} << k; r = t[15:8]; c = r[0]; end
    endcase
    if (k == 3'd0) c = 1'b0;
    return {c, r};
  endfunction

  task automatic push_exp(input logic [7:0] d, input logic c, input bit lat);
    exp_t e;
    e.data = d; e.carry = c; e.cyc = cyc; e.chk_lat = lat;
    sbq.push_back(e);
  endtask

  // Output side of the scoreboard: every completed output transfer is popped and compared.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      assert (sbq.size() != 0) else begin
        n_fail++;
        $error("FAIL stray_output observed=%0h expected=no_output", out);
      end
      if (sbq.size() != 0) begin
        exp_t e;
        e = sbq.pop_front();
        chk("out_data", 64'(out), 64'(e.data));
`ifdef BARREL_CARRY_OUT_EN
        chk("out_carry", 64'(out_carry), 64'(e.carry));
`endif
        if (e.chk_lat) chk("latency", 64'(cyc - e.cyc), 64'(SW));
      end
    end
  end

  task automatic send(input logic [7:0] x, input logic [2:0] k, input logic [1:0] m,
                      input logic [7:0] ed, input logic ec, input bit lat);
    bit acc = 0;
    int t = 0;
    a = x; b = k; mode = m; in_valid = 1'b1;
    while (!acc && t < 50) begin
      @(negedge clk);
      if (in_ready) acc = 1;
      else begin @(posedge clk); #2; end
      t++;
    end
    n_checks++;
    assert (acc) else begin
      n_fail++;
      $error("FAIL send_accept observed=stalled expected=accepted");
    end
    if (acc) push_exp(ed, ec, lat);
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic sendm(input logic [7:0] x, input logic [2:0] k, input logic [1:0] m);
    logic [8:0] r;
    r = model8(x, k, m);
    send(x, k, m, r[7:0], r[8], 1'b1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic drain();
    int t = 0;
    in_valid = 1'b0;
    while (sbq.size() != 0 && t < 100) begin @(posedge clk); #2; t++; end
    chk("drain_empty", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0]  sweep_d [8] = '{8'b10110011, 8'b01100110, 8'b11001100, 8'b10011000,
                                8'b00110000, 8'b01100000, 8'b11000000, 8'b10000000};
  logic        sweep_c [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [31:0] w_a   [3] = '{32'h8000_0001, 32'h8000_0001, 32'h8000_0001};
  logic [4:0]  w_b   [3] = '{5'd31, 5'd1, 5'd31};
  logic [1:0]  w_m   [3] = '{2'b10, 2'b11, 2'b01};
  logic [31:0] w_exp [3] = '{32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0001};
  logic        w_c   [3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    int j;
    logic [8:0] r;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; mode = '0; out_ready = 1'b1;
    in_valid32 = 1'b0; a32 = '0; b32 = '0; mode32 = '0; out_ready32 = 1'b1;
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_out_valid32", 64'(out_valid32), 64'd0);
`ifdef BARREL_CARRY_OUT_EN
    chk("rst_out_carry", 64'(out_carry), 64'd0);
`endif
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    idle(1);

    // Four modes back-to-back, a=10110011, b=3
    send(8'b10110011, 3'd3, 2'b00, 8'b10011000, 1'b1, 1'b1);
    send(8'b10110011, 3'd3, 2'b01, 8'b00010110, 1'b0, 1'b1);
    send(8'b10110011, 3'd3, 2'b10, 8'b11110110, 1'b0, 1'b1);
    send(8'b10110011, 3'd3, 2'b11, 8'b10011101, 1'b1, 1'b1);
    drain();

    // LSL sweep b=0..7, one per cycle
    for (int k = 0; k < 8; k++) send(8'b10110011, 3'(k), 2'b00, sweep_d[k], sweep_c[k], 1'b1);
    drain();

    // Backpressure: consumer stalled while 1,2,3,4 are offered
    out_ready = 1'b0;
    j = 0;
    for (int t = 0; t < 8; t++) begin
      a = 8'(j + 1); b = 3'd0; mode = 2'b00; in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin push_exp(8'(j + 1), 1'b0, 1'b0); j++; end
      if (t >= 3) begin
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_out_valid_hold", 64'(out_valid), 64'd1);
        chk("bp_out_hold", 64'(out), 64'd1);
      end
      @(posedge clk); #2;
    end
    chk("bp_items_held", 64'(j), 64'd3);
    out_ready = 1'b1;
    a = 8'd4;
    @(negedge clk);
    chk("bp_resume_ready", 64'(in_ready), 64'd1);
    if (in_ready) push_exp(8'd4, 1'b0, 1'b0);
    @(posedge clk); #2;
    in_valid = 1'b0;
    drain();

    // Random operands, all modes
    for (int n = 0; n < 24; n++) sendm(8'($urandom), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
    drain();

    // Bubbles: in_valid 1,0,1,0
    for (int t = 0; t < 10; t++) begin
      in_valid = (t < 4) && (t % 2 == 0);
      a = 8'(t * 37 + 5); b = 3'(t + 1); mode = 2'(t / 2);
      @(negedge clk);
      if (in_valid && in_ready) begin
        r = model8(a, b, mode);
        push_exp(r[7:0], r[8], 1'b1);
      end
      if (t >= 3) chk("bubble_valid", 64'(out_valid), 64'((t - 3 < 4) && ((t - 3) % 2 == 0)));
      @(posedge clk); #2;
    end
    drain();

    // WIDTH=32, five-cycle latency
    for (int t = 0; t < 9; t++) begin
      if (t < 3) begin
        in_valid32 = 1'b1; a32 = w_a[t]; b32 = w_b[t]; mode32 = w_m[t];
      end else begin
        in_valid32 = 1'b0;
      end
      @(negedge clk);
      if (t < 3) chk("w32_in_ready", 64'(in_ready32), 64'd1);
      if (t == 4 || t == 8) chk("w32_latency_gap", 64'(out_valid32), 64'd0);
      if (t >= 5 && t < 8) begin
        chk("w32_out_valid", 64'(out_valid32), 64'd1);
        chk("w32_out", 64'(out32), 64'(w_exp[t-5]));
`ifdef BARREL_CARRY_OUT_EN
        chk("w32_out_carry", 64'(out_carry32), 64'(w_c[t-5]));
`endif
      end
      @(posedge clk); #2;
    end

    // Reset while two items are in flight
    send(8'hA5, 3'd0, 2'b00, 8'hA5, 1'b0, 1'b1);
    idle(1);
    send(8'h5A, 3'd1, 2'b01, 8'h2D, 1'b0, 1'b1);
    chk("mid_pre_valid", 64'(out_valid), 64'd1);
    #1;
    rst = 1'b1;
    sbq.delete();
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out", 64'(out), 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("mid_rel_in_ready", 64'(in_ready), 64'd1);
    idle(8);
    sendm(8'hC3, 3'd2, 2'b10);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
